// File: rtl/seq_divider32_if.sv
// rtl/seq_divider32_if.sv - issue/result bundle between the ALU issuing logic and the sequential divider
interface seq_divider32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SGN;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DZ;
    logic             V;

    modport master (
        output start, A, B, SGN,
        input  busy, done, Q, R, DZ, V
    );

    modport slave (
        input  start, A, B, SGN,
        output busy, done, Q, R, DZ, V
    );
endinterface

// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle signed/unsigned restoring divider, one quotient bit per clock
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    seq_divider32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [WIDTH-1:0] q_r, r_r;
    logic             dz_r, v_r;
    logic             s_a, s_b, ovf;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_abs, b_abs, rem_shift;
    logic [WIDTH:0]   trial;
    logic             a_neg, b_neg;

    assign a_neg     = bus.SGN & bus.A[WIDTH-1];
    assign b_neg     = bus.SGN & bus.B[WIDTH-1];
    assign a_abs     = a_neg ? -bus.A : bus.A;
    assign b_abs     = b_neg ? -bus.B : bus.B;
    assign rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    // Partial remainder keeps its shifted-out MSB so divisors above 2^(W-1) still work.
    assign trial     = {rem, dvd[WIDTH-1]} - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            q_r  <= '0;
            r_r  <= '0;
            dz_r <= 1'b0;
            v_r  <= 1'b0;
            s_a  <= 1'b0;
            s_b  <= 1'b0;
            ovf  <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd  <= a_abs;
                        dvs  <= b_abs;
                        s_a  <= a_neg;
                        s_b  <= b_neg;
                        ovf  <= bus.SGN && (bus.A == MOST_NEG) && (bus.B == '1);
                        rem  <= '0;
                        cnt  <= '0;
                        dz_r <= 1'b0;
                        v_r  <= 1'b0;
                        if (bus.B == '0) begin
                            q_r  <= '1;
                            r_r  <= bus.A;
                            dz_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    q_r <= (s_a ^ s_b) ? -dvd : dvd;
                    r_r <= s_a ? -rem : rem;
                    v_r <= ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == CALC) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.Q    = q_r;
    assign bus.R    = r_r;
    assign bus.DZ   = dz_r;
    assign bus.V    = v_r;
endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - directed bench for seq_divider32
module tb_seq_divider32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_divider32_if #(.WIDTH(32)) bus ();

    seq_divider32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle; returns in the done cycle (or after the bound).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output logic bsy1);
        bus.A     = a;
        bus.B     = b;
        bus.SGN   = s;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.SGN   = ~s;
        lat  = 1;
        bsy1 = bus.busy;
        while (bus.done !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   pulses;
        int   done_at;
        logic bsy1;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.SGN   = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_q", bus.Q, 32'd0);
        chk("rst_r", bus.R, 32'd0);
        chk("rst_dz_v", {30'd0, bus.DZ, bus.V}, 32'd0);
        rst = 1'b0;
        step();

        run_div(32'd100, 32'd7, 1'b0, lat, bsy1);
        chk("u100_lat", lat, 32'd34);
        chk("u100_busy1", {31'd0, bsy1}, 32'd1);
        chk("u100_busy_done", {31'd0, bus.busy}, 32'd0);
        chk("u100_q", bus.Q, 32'h0000000E);
        chk("u100_r", bus.R, 32'h00000002);
        chk("u100_dz_v", {30'd0, bus.DZ, bus.V}, 32'd0);
        step();
        chk("u100_done_once", {31'd0, bus.done}, 32'd0);
        chk("u100_q_hold", bus.Q, 32'h0000000E);

        run_div(32'hFFFFFFF9, 32'd2, 1'b1, lat, bsy1);
        chk("s7_lat", lat, 32'd34);
        chk("s7_q", bus.Q, 32'hFFFFFFFD);
        chk("s7_r", bus.R, 32'hFFFFFFFF);
        step();

        run_div(32'hFFFFFFF9, 32'd2, 1'b0, lat, bsy1);
        chk("u7_q", bus.Q, 32'h7FFFFFFC);
        chk("u7_r", bus.R, 32'h00000001);
        step();

        run_div(32'h00001234, 32'd0, 1'b0, lat, bsy1);
        chk("dz_lat", lat, 32'd1);
        chk("dz_busy1", {31'd0, bsy1}, 32'd0);
        chk("dz_q", bus.Q, 32'hFFFFFFFF);
        chk("dz_r", bus.R, 32'h00001234);
        chk("dz_flags", {30'd0, bus.DZ, bus.V}, 32'd2);
        step();

        run_div(32'd100, 32'd7, 1'b0, lat, bsy1);
        chk("dz_clear_flags", {30'd0, bus.DZ, bus.V}, 32'd0);
        chk("dz_clear_q", bus.Q, 32'h0000000E);
        step();

        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bsy1);
        chk("ovf_q", bus.Q, 32'h80000000);
        chk("ovf_r", bus.R, 32'd0);
        chk("ovf_flags", {30'd0, bus.DZ, bus.V}, 32'd1);
        step();

        run_div(32'hFFFFFFFF, 32'd1, 1'b0, lat, bsy1);
        chk("umax_q", bus.Q, 32'hFFFFFFFF);
        chk("umax_r", bus.R, 32'd0);
        chk("umax_flags", {30'd0, bus.DZ, bus.V}, 32'd0);
        step();

        // A second start at cycle n+10 must be dropped.
        bus.A = 32'd50; bus.B = 32'd5; bus.SGN = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        pulses  = 0;
        done_at = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = cyc;
            end
            if (cyc == 10) begin
                bus.A = 32'd9; bus.B = 32'd3; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        chk("busy_start_pulses", pulses, 32'd1);
        chk("busy_start_lat", done_at, 32'd34);
        chk("busy_start_q", bus.Q, 32'd10);
        chk("busy_start_r", bus.R, 32'd0);

        // Reset lands in cycle n+15 of an operation.
        bus.A = 32'd1000; bus.B = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 15; cyc++) step();
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_q", bus.Q, 32'd0);
        chk("mid_rst_r", bus.R, 32'd0);
        chk("mid_rst_flags", {30'd0, bus.DZ, bus.V}, 32'd0);
        pulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done === 1'b1) pulses++;
            step();
        end
        chk("mid_rst_no_done", pulses, 32'd0);

        run_div(32'd81, 32'd9, 1'b0, lat, bsy1);
        chk("post_rst_lat", lat, 32'd34);
        chk("post_rst_q", bus.Q, 32'd9);
        chk("post_rst_r", bus.R, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Multi-cycle 32-bit integer divider, signed or unsigned; the sequential counterpart to the team's combinational add/sub datapath.
- Computes one quotient bit per clock by restoring trial-subtraction.
- Sits beside the adder in the ALU. The issuing logic pulses start and waits for done.

Parameters:
WIDTH, 32, operand/result width in bits (all arithmetic rules below are stated for WIDTH; tests use 32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
A  input  WIDTH  dividend, captured on accept
B  input  WIDTH  divisor, captured on accept
SGN  input  1  1 = two's-complement signed divide, 0 = unsigned; captured on accept
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; Q/R/DZ/V valid from this cycle
Q  output  WIDTH  quotient
R  output  WIDTH  remainder
DZ  output  1  divide-by-zero flag
V  output  1  signed overflow flag (most-negative / -1)

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: busy=0, done=0, Q=0, R=0, DZ=0, V=0; state=IDLE; iteration counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start=1 at edge n, capture A, B, SGN, then:
  - B==0 -> DONE.
  - Otherwise -> CALC.
  - On the same edge, when SGN=1: store |A|, |B| plus sign bits sA=A[W-1], sB=B[W-1].
  - When SGN=0: store raw A, B; sA=sB=0.
  - Clear remainder register; counter=0.
- CALC, once per cycle:
  - rem = {rem[W-2:0], dvd[W-1]}; dvd shifts left.
  - trial = rem - dvs, computed W+1 bits wide.
  - If trial is non-negative: rem=trial and shift 1 into dvd[0]; else shift 0.
  - After W iterations (counter==W-1) -> FIX.
- FIX:
  - Q = (sA^sB) ? -quot : quot.
  - R = sA ? -rem : rem.
  - V = SGN & (A==most-negative) & (B==all ones).
  - -> DONE.
- DONE: done=1 for exactly this cycle; -> IDLE. Results are stable from here until the next accepted start reaches DONE.
- Divide by zero: DONE directly after the accept edge; Q = all ones, R = captured A (raw), DZ=1, V=0.
- Signed overflow (most-negative / -1): Q = most-negative, R = 0, V=1. This result falls out of the algorithm naturally; no special datapath.
- DZ and V are cleared on the next accept.
- Timing, start accepted at the end of cycle n:
  - busy=1 in cycles n+1 .. n+W+1.
  - done=1 in cycle n+W+2 (n+34 for W=32), with busy=0.
  - Divide by zero: done=1 in cycle n+1, with busy=0 throughout.
- busy=1 in CALC and FIX only; 0 in IDLE and DONE.
- start while busy=1 is ignored (not queued).
- start high in the DONE cycle is not accepted; the earliest back-to-back accept is the cycle after done.
- A/B/SGN changes after accept have no effect.
- rst during any state: return to IDLE next edge; outputs cleared to reset values; done not pulsed for the aborted operation.
- Remainder magnitude is always < |divisor|. Sign rules: quotient truncates toward zero; remainder takes the dividend's sign.

Test Plan:
- Unsigned: A=100, B=7, SGN=0 -> Q=0x0000000E, R=0x00000002, DZ=0, V=0; done exactly 34 cycles after the accept cycle.
- Signed: A=0xFFFFFFF9 (-7), B=2, SGN=1 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1); same case with SGN=0 -> Q=0x7FFFFFFC, R=0x00000001.
- Divide by zero: A=0x00001234, B=0 -> done 1 cycle after accept; Q=0xFFFFFFFF, R=0x00001234, DZ=1, busy never high. A following valid divide must clear DZ.
- Overflow: A=0x80000000, B=0xFFFFFFFF, SGN=1 -> Q=0x80000000, R=0, V=1. Also unsigned A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0, V=0.
- Start while busy: accept A=50, B=5; pulse start with A=9, B=3 at cycle n+10 -> ignored; result Q=10, R=0, single done pulse.
- Reset mid-operation: assert rst at cycle n+15 -> busy=0 and all outputs 0 next cycle; no done pulse. A fresh start with A=81, B=9 afterwards -> Q=9, R=0.
